// File: rtl/nibble_serial_alu_sequencer.sv
// Serialises wide operands onto a 4-bit adder slice, one nibble per cycle,
// LSB first, chaining carry-out back as carry-in, and returns the assembled
// result with carry and zero flags over a valid/ready handshake.
module nibble_serial_alu_sequencer #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_s1,
   input  logic                   in_s0,
   input  logic [4*NIBBLES-1:0]   in_a,
   input  logic [4*NIBBLES-1:0]   in_b,
   input  logic                   in_cin,
   output logic                   fa_s1,
   output logic                   fa_s0,
   output logic [3:0]             fa_a,
   output logic [3:0]             fa_b,
   output logic                   fa_cin,
   input  logic [3:0]             fa_s,
   input  logic                   fa_cout,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   out_s,
   output logic                   out_cout,
   output logic                   out_zero,
   output logic                   busy
);

   localparam int unsigned W     = 4 * NIBBLES;
   localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q,     state_d;
   logic [W-1:0]     a_q,         a_d;
   logic [W-1:0]     b_q,         b_d;
   logic [W-1:0]     res_q,       res_d;
   logic             carry_q,     carry_d;
   logic [IDX_W-1:0] idx_q,       idx_d;
   logic [1:0]       mode_q,      mode_d;
   logic [3:0]       fa_a_q,      fa_a_d;
   logic [3:0]       fa_b_q,      fa_b_d;
   logic             fa_cin_q,    fa_cin_d;
   logic             in_ready_q,  in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [W-1:0]     out_s_q,     out_s_d;
   logic             out_cout_q,  out_cout_d;
   logic             out_zero_q,  out_zero_d;
   logic             busy_q,      busy_d;

   // Operands shift right one nibble per RUN cycle; sums enter at the top so
   // that after NIBBLES cycles nibble 0 sits at the bottom of the result.
   logic [W-1:0] res_shift;
   assign res_shift = {fa_s, res_q[W-1:4]};

   // State register and all registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         a_q         <= '0;
         b_q         <= '0;
         res_q       <= '0;
         carry_q     <= 1'b0;
         idx_q       <= '0;
         mode_q      <= '0;
         fa_a_q      <= '0;
         fa_b_q      <= '0;
         fa_cin_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_s_q     <= '0;
         out_cout_q  <= 1'b0;
         out_zero_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_q       <= res_d;
         carry_q     <= carry_d;
         idx_q       <= idx_d;
         mode_q      <= mode_d;
         fa_a_q      <= fa_a_d;
         fa_b_q      <= fa_b_d;
         fa_cin_q    <= fa_cin_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_s_q     <= out_s_d;
         out_cout_q  <= out_cout_d;
         out_zero_q  <= out_zero_d;
         busy_q      <= busy_d;
      end
   end

   // Next-state and next-output decode; adder-side outputs are precomputed
   // one cycle ahead so they present the current nibble during each RUN cycle.
   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      res_d       = res_q;
      carry_d     = carry_q;
      idx_d       = idx_q;
      mode_d      = mode_q;
      fa_a_d      = fa_a_q;
      fa_b_d      = fa_b_q;
      fa_cin_d    = fa_cin_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_s_d     = out_s_q;
      out_cout_d  = out_cout_q;
      out_zero_d  = out_zero_q;
      busy_d      = busy_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d    = S_RUN;
               a_d        = in_a;
               b_d        = in_b;
               res_d      = '0;
               carry_d    = in_cin;
               idx_d      = '0;
               mode_d     = {in_s1, in_s0};
               fa_a_d     = in_a[3:0];
               fa_b_d     = in_b[3:0];
               fa_cin_d   = in_cin;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
            end
         end
         S_RUN: begin
            res_d   = res_shift;
            carry_d = fa_cout;
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            if (idx_q == IDX_W'(NIBBLES - 1)) begin
               state_d     = S_DONE;
               fa_a_d      = '0;
               fa_b_d      = '0;
               fa_cin_d    = 1'b0;
               out_valid_d = 1'b1;
               out_s_d     = res_shift;
               out_cout_d  = fa_cout;
               out_zero_d  = (res_shift == '0);
            end else begin
               idx_d    = idx_q + IDX_W'(1);
               fa_a_d   = a_q[7:4];
               fa_b_d   = b_q[7:4];
               fa_cin_d = fa_cout;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               busy_d      = 1'b0;
            end
         end
         default: begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
            busy_d      = 1'b0;
         end
      endcase
   end

   assign in_ready  = in_ready_q;
   assign fa_s1     = mode_q[1];
   assign fa_s0     = mode_q[0];
   assign fa_a      = fa_a_q;
   assign fa_b      = fa_b_q;
   assign fa_cin    = fa_cin_q;
   assign out_valid = out_valid_q;
   assign out_s     = out_s_q;
   assign out_cout  = out_cout_q;
   assign out_zero  = out_zero_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_nibble_serial_alu_sequencer.sv
// Directed bench for the nibble-serial sequencer with a behavioural 4-bit adder.
module tb_nibble_serial_alu_sequencer;

   localparam int unsigned NIB = 4;
   localparam int unsigned W   = 4 * NIB;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         in_s1, in_s0;
   logic [W-1:0] in_a, in_b;
   logic         in_cin;
   logic         fa_s1, fa_s0;
   logic [3:0]   fa_a, fa_b;
   logic         fa_cin;
   logic [3:0]   fa_s;
   logic         fa_cout;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_s;
   logic         out_cout;
   logic         out_zero;
   logic         busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Behavioural adder slice driven from the sequencer's fa_* outputs.
   assign {fa_cout, fa_s} = 5'(fa_a) + 5'(fa_b) + 5'(fa_cin);

   nibble_serial_alu_sequencer #(.NIBBLES(NIB)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_s1(in_s1), .in_s0(in_s0),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
      .fa_s1(fa_s1), .fa_s0(fa_s0),
      .fa_a(fa_a), .fa_b(fa_b), .fa_cin(fa_cin),
      .fa_s(fa_s), .fa_cout(fa_cout),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_s(out_s), .out_cout(out_cout), .out_zero(out_zero),
      .busy(busy)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one operation and follow it through RUN into DONE.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [1:0] mode, input logic [W-1:0] exp_s,
                         input logic exp_cout, input logic exp_zero);
      logic       c;
      logic [3:0] na, nb;
      logic [4:0] sum;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      {in_s1, in_s0} = mode;
      tick();
      in_valid = 1'b0;
      c = cin;
      for (int i = 0; i < int'(NIB); i++) begin
         na  = a[4*i +: 4];
         nb  = b[4*i +: 4];
         chk("run_fa_a",      32'(fa_a),      32'(na));
         chk("run_fa_b",      32'(fa_b),      32'(nb));
         chk("run_fa_cin",    32'(fa_cin),    32'(c));
         chk("run_mode",      32'({fa_s1, fa_s0}), 32'(mode));
         chk("run_out_valid", 32'(out_valid), 32'd0);
         chk("run_in_ready",  32'(in_ready),  32'd0);
         chk("run_busy",      32'(busy),      32'd1);
         sum = 5'(na) + 5'(nb) + 5'(c);
         c   = sum[4];
         tick();
      end
      chk("done_out_valid", 32'(out_valid), 32'd1);
      chk("done_out_s",     32'(out_s),     32'(exp_s));
      chk("done_out_cout",  32'(out_cout),  32'(exp_cout));
      chk("done_out_zero",  32'(out_zero),  32'(exp_zero));
      chk("done_in_ready",  32'(in_ready),  32'd0);
      chk("done_busy",      32'(busy),      32'd1);
      chk("done_fa_a",      32'(fa_a),      32'd0);
      chk("done_mode",      32'({fa_s1, fa_s0}), 32'(mode));
   endtask

   // Hand the result off and confirm the return to IDLE.
   task automatic release_out();
      out_ready = 1'b1;
      tick();
      chk("rel_out_valid", 32'(out_valid), 32'd0);
      chk("rel_in_ready",  32'(in_ready),  32'd1);
      chk("rel_busy",      32'(busy),      32'd0);
      out_ready = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_s1     = 1'b0;
      in_s0     = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b0;

      // Reset
      tick();
      tick();
      rst = 1'b0;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_out_zero",  32'(out_zero),  32'd1);
      chk("rst_out_s",     32'(out_s),     32'd0);
      chk("rst_fa_a",      32'(fa_a),      32'd0);
      chk("rst_fa_b",      32'(fa_b),      32'd0);
      chk("rst_fa_cin",    32'(fa_cin),    32'd0);
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Add with carry chain
      run_op(16'h1234, 16'h0FCD, 1'b0, 2'b00, 16'h2201, 1'b0, 1'b0);
      release_out();

      // Wrap-around
      run_op(16'hFFFF, 16'h0001, 1'b0, 2'b00, 16'h0000, 1'b1, 1'b1);
      release_out();
      chk("idle_keeps_cout", 32'(out_cout), 32'd1);

      // Carry-in with mode held at 10
      run_op(16'h0000, 16'h0000, 1'b1, 2'b10, 16'h0001, 1'b0, 1'b0);
      release_out();

      // Backpressure while a new request is pulsed
      run_op(16'h00FF, 16'h0001, 1'b0, 2'b01, 16'h0100, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_a     = 16'h1111;
         in_b     = 16'h2222;
         in_cin   = 1'b0;
         {in_s1, in_s0} = 2'b00;
         tick();
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_out_s",     32'(out_s),     32'h0100);
         chk("bp_in_ready",  32'(in_ready),  32'd0);
         chk("bp_fa_a",      32'(fa_a),      32'd0);
         chk("bp_mode",      32'({fa_s1, fa_s0}), 32'd1);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_rel_out_valid", 32'(out_valid), 32'd0);
      chk("bp_rel_in_ready",  32'(in_ready),  32'd1);
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("bp_acc_busy",     32'(busy),      32'd1);
      chk("bp_acc_in_ready", 32'(in_ready),  32'd0);
      chk("bp_acc_fa_a",     32'(fa_a),      32'd1);
      chk("bp_acc_fa_b",     32'(fa_b),      32'd2);
      chk("bp_acc_mode",     32'({fa_s1, fa_s0}), 32'd0);
      for (int i = 0; i < int'(NIB); i++) tick();
      chk("bp2_out_valid", 32'(out_valid), 32'd1);
      chk("bp2_out_s",     32'(out_s),     32'h3333);
      chk("bp2_out_zero",  32'(out_zero),  32'd0);
      release_out();

      // Reset during the second RUN cycle
      in_valid = 1'b1;
      in_a     = 16'hFFFF;
      in_b     = 16'h0001;
      in_cin   = 1'b0;
      {in_s1, in_s0} = 2'b11;
      tick();
      in_valid = 1'b0;
      tick();
      chk("mid_busy_pre", 32'(busy), 32'd1);
      chk("mid_fa_a_pre", 32'(fa_a), 32'hF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_in_ready",  32'(in_ready),  32'd1);
      chk("mid_busy",      32'(busy),      32'd0);
      chk("mid_out_valid", 32'(out_valid), 32'd0);
      chk("mid_out_s",     32'(out_s),     32'd0);
      chk("mid_out_zero",  32'(out_zero),  32'd1);
      chk("mid_fa_a",      32'(fa_a),      32'd0);
      chk("mid_mode",      32'({fa_s1, fa_s0}), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("mid_no_valid", 32'(out_valid), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
